// File: rtl/issue_dual_collector_pkg.sv
// Shared types and constants for the dual-lane issue collector.
// Statistics counters (ISSUE_DUAL_COLLECTOR_STATS_EN) use STAT_W.
package issue_dual_collector_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int STAT_W     = 16;

    typedef logic [DEF_DATA_W-1:0] entry_t;
endpackage

// File: rtl/issue_dual_collector_stats.sv
// Saturating activity counters for the issue collector.
// Built only when ISSUE_DUAL_COLLECTOR_STATS_EN is defined.
module issue_dual_collector_stats
    import issue_dual_collector_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              fire0,
    input  logic              fire1,
    input  logic              in0_valid,
    input  logic              in0_ready,
    output logic [STAT_W-1:0] stat_pushed,
    output logic [STAT_W-1:0] stat_dual,
    output logic [STAT_W-1:0] stat_stall
);
    localparam int SUM_W = STAT_W + 1;
    localparam logic [STAT_W-1:0] SAT = '1;

    // One extra bit catches overflow when two entries land at FFFE/FFFF.
    logic [SUM_W-1:0] pushed_sum;
    assign pushed_sum = {1'b0, stat_pushed} + SUM_W'(fire0) + SUM_W'(fire1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pushed <= '0;
            stat_dual   <= '0;
            stat_stall  <= '0;
        end else if (flush) begin
            stat_pushed <= '0;
            stat_dual   <= '0;
            stat_stall  <= '0;
        end else begin
            stat_pushed <= pushed_sum[STAT_W] ? SAT : pushed_sum[STAT_W-1:0];
            if (fire1 && stat_dual != SAT)
                stat_dual <= stat_dual + STAT_W'(1);
            if (in0_valid && !in0_ready && stat_stall != SAT)
                stat_stall <= stat_stall + STAT_W'(1);
        end
    end
endmodule

// File: rtl/issue_dual_collector.sv
// Two-lane in-order collector: buffers up to two entries per cycle, drains one.
// Optional ISSUE_DUAL_COLLECTOR_STATS_EN adds stat_pushed/stat_dual/stat_stall.
module issue_dual_collector
    import issue_dual_collector_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
`ifdef ISSUE_DUAL_COLLECTOR_STATS_EN
    output logic [STAT_W-1:0] stat_pushed,
    output logic [STAT_W-1:0] stat_dual,
    output logic [STAT_W-1:0] stat_stall,
`endif
    output logic [CNT_W-1:0]  occupancy
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fire0, fire1, pop;

    // Readiness looks only at the registered count, never at out_ready/flush.
    assign in0_ready = !sys_rst && (count != CNT_W'(DEPTH));
    assign in1_ready = !sys_rst && (count <  CNT_W'(DEPTH - 1));

    assign fire0 = in0_valid && in0_ready;
    assign fire1 = fire0 && in1_valid && in1_ready;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign occupancy = count;

    // Storage is cleared on reset so out_data reads 0 until the first write.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fire0) mem[wr_ptr] <= in0_data;
            if (fire1) mem[wr_ptr + PTR_W'(1)] <= in1_data;
            wr_ptr <= wr_ptr + PTR_W'(fire0) + PTR_W'(fire1);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(fire0) + CNT_W'(fire1) - CNT_W'(pop);
        end
    end

`ifdef ISSUE_DUAL_COLLECTOR_STATS_EN
    issue_dual_collector_stats u_stats (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .flush       (flush),
        .fire0       (fire0),
        .fire1       (fire1),
        .in0_valid   (in0_valid),
        .in0_ready   (in0_ready),
        .stat_pushed (stat_pushed),
        .stat_dual   (stat_dual),
        .stat_stall  (stat_stall)
    );
`endif
endmodule

// File: tb/tb_issue_dual_collector.sv
// Self-checking bench for issue_dual_collector against a queue-based reference.
// Stats checks are compiled in with ISSUE_DUAL_COLLECTOR_STATS_EN.
module tb_issue_dual_collector;
    import issue_dual_collector_pkg::*;

    localparam int DEPTH = 8;

    logic       sys_clk = 1'b0;
    logic       sys_rst, flush;
    logic       in0_valid, in1_valid, out_ready;
    entry_t     in0_data, in1_data, out_data;
    logic       in0_ready, in1_ready, out_valid;
    logic [3:0] occupancy;
`ifdef ISSUE_DUAL_COLLECTOR_STATS_EN
    logic [15:0] stat_pushed, stat_dual, stat_stall;
`endif

    int checks = 0;
    int errors = 0;
    entry_t q[$];
    int m_pushed = 0, m_dual = 0, m_stall = 0;

    always #5 sys_clk = ~sys_clk;

    issue_dual_collector #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .flush     (flush),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef ISSUE_DUAL_COLLECTOR_STATS_EN
        .stat_pushed (stat_pushed),
        .stat_dual   (stat_dual),
        .stat_stall  (stat_stall),
`endif
        .occupancy (occupancy)
    );

    // Drive one cycle from the negedge, advance the reference model at the posedge.
    task automatic step(input logic v0, input entry_t d0, input logic v1, input entry_t d1,
                        input logic ordy, input logic fl);
        bit r0, r1, f0, f1, p;
        in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1;
        out_ready = ordy; flush = fl;
        r0 = q.size() < DEPTH;
        r1 = q.size() <= DEPTH - 2;
        f0 = v0 && r0;
        f1 = f0 && v1 && r1;
        p  = (q.size() != 0) && ordy;
        @(posedge sys_clk);
        if (fl) begin
            q.delete();
            m_pushed = 0; m_dual = 0; m_stall = 0;
        end else begin
            if (p) void'(q.pop_front());
            if (f0) q.push_back(d0);
            if (f1) q.push_back(d1);
            m_pushed = m_pushed + int'(f0) + int'(f1);
            if (m_pushed > 65535) m_pushed = 65535;
            if (f1 && m_dual < 65535) m_dual++;
            if (v0 && !r0 && m_stall < 65535) m_stall++;
        end
        @(negedge sys_clk);
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
        in0_data = 8'hAA; in1_data = 8'hBB; out_ready = 1'b1; flush = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL reset_in0_ready got %b want 0", in0_ready); end
        checks++; if (in1_ready !== 1'b0) begin errors++; $display("FAIL reset_in1_ready got %b want 0", in1_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        sys_rst = 1'b0;
        q.delete(); m_pushed = 0; m_dual = 0; m_stall = 0;
        #1;
        checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL release_in0_ready got %b want 1", in0_ready); end
        checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL release_in1_ready got %b want 1", in1_ready); end
        @(negedge sys_clk);
    endtask

    task automatic test_dual_push_drain();
        entry_t exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(1, 8'h11, 1, 8'h22, 0, 0);
        step(1, 8'h33, 1, 8'h44, 0, 0);
        checks++; if (occupancy !== 4'd4) begin errors++; $display("FAIL dual_occupancy got %0d want 4", occupancy); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++; $display("FAIL dual_drain[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp[i]);
            end
            step(0, 0, 0, 0, 1, 0);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dual_empty_valid got %b want 0", out_valid); end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 3; i++) step(1, entry_t'(8'h01 + 2*i), 1, entry_t'(8'h02 + 2*i), 0, 0);
        step(1, 8'h07, 0, 0, 0, 0);
        checks++; if (occupancy !== 4'd7 || in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL fill7 got occ=%0d r0=%b r1=%b want occ=7 r0=1 r1=0", occupancy, in0_ready, in1_ready);
        end
        step(1, 8'h55, 1, 8'h66, 0, 0);
        checks++; if (occupancy !== 4'd8 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
            errors++; $display("FAIL full8 got occ=%0d r0=%b r1=%b want occ=8 r0=0 r1=0", occupancy, in0_ready, in1_ready);
        end
        // Full: an offer is stalled and must not disturb contents.
        step(1, 8'h99, 1, 8'h98, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== q[0]) begin
                errors++; $display("FAIL full_drain[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, q[0]);
            end
            step(0, 0, 0, 0, 1, 0);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty_valid got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        entry_t exp [4] = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
        step(0, 0, 0, 0, 0, 1);              // pointers back to 0
        for (int i = 0; i < 3; i++) step(1, entry_t'(8'h20 + i), 1, entry_t'(8'h30 + i), 0, 0);
        step(1, 8'h40, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0);   // wr_ptr=rd_ptr=7
        step(1, 8'hA1, 1, 8'hA2, 0, 0);      // slots 7 and 0
        step(1, 8'hB1, 1, 8'hB2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++; $display("FAIL wrap_drain[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp[i]);
            end
            step(0, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_lane1_only();
        step(1, 8'h12, 0, 0, 0, 0);
        step(0, 0, 1, 8'h77, 0, 0);
        checks++; if (occupancy !== 4'd1 || out_data !== 8'h12) begin
            errors++; $display("FAIL lane1_only got occ=%0d d=%h want occ=1 d=12", occupancy, out_data);
        end
        step(0, 0, 0, 0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lane1_only_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        step(1, 8'h01, 1, 8'h02, 0, 0);
        step(1, 8'h03, 1, 8'h04, 0, 0);
        step(1, 8'h05, 0, 0, 0, 0);
        checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL flush_pre_occ got %0d want 5", occupancy); end
        step(1, 8'hE1, 1, 8'hE2, 1, 1);
        checks++; if (occupancy !== 4'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_post got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
        end
        checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b1) begin
            errors++; $display("FAIL flush_readies got r0=%b r1=%b want 1 1", in0_ready, in1_ready);
        end
`ifdef ISSUE_DUAL_COLLECTOR_STATS_EN
        checks++; if (stat_pushed !== 16'd0 || stat_dual !== 16'd0 || stat_stall !== 16'd0) begin
            errors++; $display("FAIL flush_stats got %0d %0d %0d want 0 0 0", stat_pushed, stat_dual, stat_stall);
        end
`endif
    endtask

    task automatic test_reset_mid();
        step(1, 8'h61, 1, 8'h62, 0, 0);
        #2 sys_rst = 1'b1;
        #1;
        checks++; if (occupancy !== 4'd0 || out_valid !== 1'b0 || in0_ready !== 1'b0) begin
            errors++; $display("FAIL reset_mid got occ=%0d v=%b r0=%b want 0 0 0", occupancy, out_valid, in0_ready);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        q.delete(); m_pushed = 0; m_dual = 0; m_stall = 0;
        @(negedge sys_clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            checks++; if (in0_ready !== (q.size() < DEPTH) || in1_ready !== (q.size() <= DEPTH - 2)) begin
                errors++; $display("FAIL rand_ready[%0d] got %b%b size=%0d", n, in0_ready, in1_ready, q.size());
            end
            checks++; if (occupancy !== 4'(q.size()) || out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_occ[%0d] got occ=%0d v=%b want occ=%0d", n, occupancy, out_valid, q.size());
            end
            if (q.size() != 0) begin
                checks++; if (out_data !== q[0]) begin
                    errors++; $display("FAIL rand_data[%0d] got %h want %h", n, out_data, q[0]);
                end
            end
`ifdef ISSUE_DUAL_COLLECTOR_STATS_EN
            checks++; if (stat_pushed !== 16'(m_pushed) || stat_dual !== 16'(m_dual) || stat_stall !== 16'(m_stall)) begin
                errors++; $display("FAIL rand_stats[%0d] got %0d %0d %0d want %0d %0d %0d", n,
                                   stat_pushed, stat_dual, stat_stall, m_pushed, m_dual, m_stall);
            end
`endif
            step(1'($urandom_range(0, 3) != 0), entry_t'($urandom), 1'($urandom_range(0, 1)),
                 entry_t'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_dual_push_drain();
        test_fill_full();
        test_wrap();
        test_lane1_only();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
